// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: multi-word add/subtract sequenced through one shared 16-bit CLA adder, LSW first.
// Optional signed-overflow capture is enabled by defining CLA_SEQ_OVF_EN.
module cla_word_sequencer #(
  parameter int WORDS = 4,
  localparam int W = 16 * WORDS,
  localparam int IW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  input  logic          req_sub,
  input  logic          req_c_in,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_sum,
  output logic          rsp_c_out,
  output logic          rsp_ovf,
  output logic [15:0]   cla_a,
  output logic [15:0]   cla_b,
  output logic          cla_c_in,
  input  logic [15:0]   cla_sum,
  input  logic          cla_c_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WORDS-1:0][15:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic sub_q, sub_d, carry_q, carry_d, c_out_q, c_out_d;
  logic [IW-1:0] idx_q, idx_d;
  logic last;
  assign last = idx_q == IW'(WORDS - 1);
  assign rsp_sum = sum_q;
  assign rsp_c_out = c_out_q;
`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  assign rsp_ovf = ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    sub_d = sub_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    idx_d = idx_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    cla_a = '0;
    cla_b = '0;
    cla_c_in = 1'b0;
`ifdef CLA_SEQ_OVF_EN
    ovf_d = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d = req_a;
          b_d = req_b;
          sub_d = req_sub;
          carry_d = req_sub | req_c_in;
          idx_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cla_a = a_q[idx_q];
        cla_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];
        cla_c_in = carry_q;
        sum_d[idx_q] = cla_sum;
        carry_d = cla_c_out;
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) begin
          c_out_d = cla_c_out;
          state_d = DONE;
`ifdef CLA_SEQ_OVF_EN
          ovf_d = (cla_a[15] == cla_b[15]) && (cla_sum[15] != cla_a[15]);
`endif
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d = rsp_ready ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      sub_q <= 1'b0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      idx_q <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      sub_q <= sub_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      idx_q <= idx_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer: scoreboard bench for cla_word_sequencer with a behavioural 16-bit adder.
module tb_cla_word_sequencer;
  localparam int WORDS = 4;
  localparam int W = 16 * WORDS;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_sub = 1'b0, req_c_in = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid, rsp_c_out, rsp_ovf, cla_c_in, cla_c_out;
  logic [W-1:0] rsp_sum;
  logic [15:0] cla_a, cla_b, cla_sum;
  int checks = 0, passes = 0;
  typedef struct {logic [W-1:0] sum; logic c; logic ovf;} exp_t;
  exp_t sb[$];

  cla_word_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_c_in(req_c_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_c_out(rsp_c_out), .rsp_ovf(rsp_ovf), .cla_a(cla_a), .cla_b(cla_b),
    .cla_c_in(cla_c_in), .cla_sum(cla_sum), .cla_c_out(cla_c_out)
  );

  assign {cla_c_out, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {16'd0, cla_c_in};
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) $display("FAIL %s: got %h expected %h", name, got, want);
    else passes++;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    exp_t e;
    logic [W:0] r;
    logic [W-1:0] bb;
    int n = 0;
    bb = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub | cin};
    e.sum = r[W-1:0];
    e.c = r[W];
`ifdef CLA_SEQ_OVF_EN
    e.ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
`else
    e.ovf = 1'b0;
`endif
    sb.push_back(e);
    req_a = a; req_b = b; req_sub = sub; req_c_in = cin; req_valid = 1'b1;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) begin checks++; $display("FAIL send_timeout: req_ready 0 expected 1"); end
    tick();
    req_valid = 1'b0;
    req_c_in = ~cin;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    checks++;
    if (!rsp_valid || sb.size() == 0) begin
      $display("FAIL %s_valid: rsp_valid %b pending %0d expected 1", name, rsp_valid, sb.size());
      return;
    end
    passes++;
    e = sb.pop_front();
    chk({name, "_sum"}, rsp_sum, e.sum);
    chk({name, "_cout"}, W'(rsp_c_out), W'(e.c));
    chk({name, "_ovf"}, W'(rsp_ovf), W'(e.ovf));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({name, "_drop"}, W'(rsp_valid), '0);
    chk({name, "_ready"}, W'(req_ready), W'(1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_rsp_sum", rsp_sum, '0);
    chk("rst_rsp_cout", W'(rsp_c_out), '0);
    chk("rst_rsp_ovf", W'(rsp_ovf), '0);
    chk("rst_cla", W'({cla_a, cla_b, cla_c_in}), '0);
  endtask

  task automatic test_add();
    int n = 0;
    send(64'h0FFF, 64'hAAA0, 1'b0, 1'b0);
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("add_latency", W'(n), W'(WORDS));
    collect("add");
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    collect("add_cin");
  endtask

  task automatic test_ripple();
    send('1, 64'h1, 1'b0, 1'b0);
    chk("ripple_cin0", W'(cla_c_in), '0);
    for (int k = 1; k < WORDS; k++) begin
      tick();
      chk($sformatf("ripple_cin%0d", k), W'(cla_c_in), W'(1));
    end
    collect("ripple");
  endtask

  task automatic test_sub();
    send(64'h5, 64'h7, 1'b1, 1'b0);
    collect("sub_neg");
    send(64'h7, 64'h5, 1'b1, 1'b0);
    collect("sub_pos");
    send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
    collect("sub_min");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] held;
    send(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0);
    while (!rsp_valid) tick();
    held = rsp_sum;
    req_a = 64'h3; req_b = 64'h4; req_sub = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", W'(rsp_valid), W'(1));
      chk("bp_req_ready", W'(req_ready), '0);
      chk("bp_stable", rsp_sum, held);
    end
    collect("bp_first");
    send(64'h3, 64'h4, 1'b0, 1'b0);
    collect("bp_second");
  endtask

  task automatic test_reset_mid();
    send(64'hFFFF_0000_FFFF_0000, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb.pop_back());
    chk("mid_req_ready", W'(req_ready), W'(1));
    chk("mid_rsp_valid", W'(rsp_valid), '0);
    chk("mid_rsp_sum", rsp_sum, '0);
    send(64'h0000_0000_0001_0002, 64'h0000_0000_0003_0004, 1'b0, 1'b0);
    collect("mid_after");
  endtask

  task automatic test_ovf();
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    collect("ovf_pos");
    send('1, 64'h1, 1'b0, 1'b0);
    collect("ovf_none");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_ovf();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cla_word_sequencer.md
Name: cla_word_sequencer

Overview:
- Multi-precision add/subtract controller that time-shares one external 16-bit carry-look-ahead adder.
- Accepts W = 16*WORDS bit operands through a valid/ready request channel.
- Feeds the adder one 16-bit slice per cycle, LSW first, and chains the carry between slices.
- Returns the full-width sum and final carry on a valid/ready response channel.

Parameters:
WORDS, 4, number of 16-bit slices per operand; W = 16*WORDS; legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request
req_a  input  W  operand A
req_b  input  W  operand B
req_sub  input  1  1 = A - B, 0 = A + B
req_c_in  input  1  carry-in for add; ignored for subtract
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_sum  output  W  result
rsp_c_out  output  1  final carry; for subtract, 1 = no borrow
rsp_ovf  output  1  signed overflow (see Optional Feature)
cla_a  output  16  slice of A driven to the shared adder
cla_b  output  16  slice of B (inverted when subtracting) driven to the adder
cla_c_in  output  1  carry into the adder
cla_sum  input  16  adder sum, combinational from cla_a/cla_b/cla_c_in
cla_c_out  input  1  adder carry-out, combinational

Behaviour:
- Synchronous, active-low reset (rst_n = 0 at a clock edge). Forces:
  - state = IDLE
  - req_ready = 1, rsp_valid = 0
  - rsp_sum = 0, rsp_c_out = 0, rsp_ovf = 0
  - cla_a = 0, cla_b = 0, cla_c_in = 0
  - internal slice index and carry register = 0
- Reset in any state aborts the operation in flight. The partial result is discarded and no response is issued.
- States:
  - IDLE: req_ready = 1.
    - On req_valid && req_ready: latch req_a, req_b, req_sub.
    - Carry register <= (req_sub ? 1 : req_c_in).
    - Index <= 0; go to RUN.
  - RUN: req_ready = 0.
    - cla_a = A[16*idx +: 16].
    - cla_b = req_sub ? ~B[16*idx +: 16] : B[16*idx +: 16].
    - cla_c_in = carry register.
    - Each edge: result[16*idx +: 16] <= cla_sum, carry register <= cla_c_out, idx <= idx + 1.
    - At the edge where idx == WORDS-1: rsp_c_out <= cla_c_out, go to DONE.
  - DONE: rsp_valid = 1; rsp_sum, rsp_c_out and rsp_ovf are stable.
    - On rsp_ready: rsp_valid drops on the next edge, go to IDLE.
    - While rsp_ready = 0, hold all outputs indefinitely.
- cla_* outputs are combinational from state and registers. In IDLE and DONE they are driven 0.
- Latency: if a request is accepted at edge E, rsp_valid is high after edge E+WORDS. The adder is used for exactly WORDS cycles.
- req_ready is 0 in RUN and DONE. No request is accepted while a result is pending. The earliest next acceptance is the cycle after response handshake.
- Widths:
  - Arithmetic is modulo 2^W.
  - Subtract uses A + ~B + 1, so rsp_c_out = 1 when A >= B (unsigned).
- req_c_in is latched only at acceptance. Later changes have no effect.
- Index and idx are sized ceil(log2(WORDS)). Index wraps to 0 on the final slice.

Optional Feature:
- Macro CLA_SEQ_OVF_EN.
- Defined:
  - Capture the MSB of cla_a, cla_b (post-inversion) and cla_sum during the final slice.
  - rsp_ovf <= (a_msb == b_msb) && (sum_msb != a_msb).
  - rsp_ovf is valid with rsp_valid and cleared by reset.
- Not defined: rsp_ovf is tied to 0 and no capture logic exists.

Test Plan:
- WORDS=4, add, A=64'h0000_0000_0000_0FFF, B=64'h0000_0000_0000_AAA0, c_in=0 -> rsp_sum=64'h0000_0000_0000_BA9F, c_out=0; rsp_valid exactly 4 cycles after acceptance.
- Ripple across all slices: A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1, c_in=0 -> sum=0, c_out=1. Also check cla_c_in=1 on slices 1..3.
- Subtract: A=64'h5, B=64'h7 -> sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0. Subtract with A=7, B=5 -> sum=2, c_out=1.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> outputs stable, req_ready=0 with req_valid=1. A second request is accepted only after rsp_ready=1; back-to-back results are correct.
- Reset mid-op: assert rst_n=0 at the 2nd RUN cycle -> next cycle req_ready=1, rsp_valid=0, rsp_sum=0. A new request then completes normally.
- CLA_SEQ_OVF_EN: A=64'h7FFF_FFFF_FFFF_FFFF, B=1 add -> sum=64'h8000_0000_0000_0000, ovf=1. A=-1, B=1 -> ovf=0. With the macro undefined, ovf=0 in both cases.
